// File: rtl/slot_access_ctrl.sv
// slot_access_ctrl: time-division access controller for one shared synchronous
// memory port. Each of eight clients posts one access; it is issued in the
// client's own slot (or in an idle slot when WORK_CONSERVE is set). The access
// is then acknowledged two cycles after its slot, with read data for reads.
module slot_access_ctrl #(
  parameter int AW            = 8,
  parameter int DW            = 16,
  parameter int WORK_CONSERVE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        slot,
  input  logic [7:0]        req,
  input  logic [7:0]        we,
  input  logic [8*AW-1:0]   addr,
  input  logic [8*DW-1:0]   wdata,
  output logic [7:0]        busy,
  output logic [7:0]        ack,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  logic [7:0]    pending_q, pending_d;
  logic [7:0]    busy_q, busy_d;
  logic [7:0]    cap_we_q;
  logic [AW-1:0] cap_addr_q  [8];
  logic [DW-1:0] cap_wdata_q [8];

  logic [7:0]    cap_set, iss_clr, done_clr;
  logic          sel_vld;
  logic [2:0]    sel_idx;

  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [2:0]    iss_owner_q;
  logic [7:0]    ack_q;
  logic          ack_wr_q;

  // Owner selection for this cycle: slot owner first, else lowest pending when conserving.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = slot;
    if (pending_q[slot]) begin
      sel_vld = 1'b1;
    end else if (WORK_CONSERVE != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) begin
          sel_vld = 1'b1;
          sel_idx = 3'(i);
        end
      end
    end
  end

  // Pending/busy bookkeeping. A capture needs busy=0 while pending or completing
  // implies busy=1, so set and clear masks never overlap on the same client.
  always_comb begin
    cap_set   = req & ~busy_q;
    iss_clr   = sel_vld  ? (8'b1 << sel_idx)     : 8'b0;
    done_clr  = mem_en_q ? (8'b1 << iss_owner_q) : 8'b0;
    pending_d = (pending_q & ~iss_clr) | cap_set;
    busy_d    = (busy_q & ~done_clr) | cap_set;
  end

  // Client request capture and per-client status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      busy_q    <= '0;
      cap_we_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        cap_addr_q[i]  <= '0;
        cap_wdata_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
      for (int i = 0; i < 8; i++) begin
        if (cap_set[i]) begin
          cap_we_q[i]    <= we[i];
          cap_addr_q[i]  <= addr[i*AW +: AW];
          cap_wdata_q[i] <= wdata[i*DW +: DW];
        end
      end
    end
  end

  // Issue stage and completion stage; the owner index rides along with mem_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      iss_owner_q <= '0;
      ack_q       <= '0;
      ack_wr_q    <= 1'b0;
    end else begin
      mem_en_q <= sel_vld;
      if (sel_vld) begin
        mem_we_q    <= cap_we_q[sel_idx];
        mem_addr_q  <= cap_addr_q[sel_idx];
        mem_wdata_q <= cap_wdata_q[sel_idx];
        iss_owner_q <= sel_idx;
      end
      ack_q    <= done_clr;
      ack_wr_q <= mem_we_q;
    end
  end

  // The memory's own output register is the completion-stage data register:
  // mem_rdata is valid exactly in the ack cycle, so it is only gated here.
  assign rdata     = (|ack_q && !ack_wr_q) ? mem_rdata : '0;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_slot_access_ctrl.sv
// Directed bench for slot_access_ctrl: a strict-TDM instance checked through an
// ack scoreboard plus per-cycle checks, and a work-conserving instance sharing
// the same stimulus for the idle-slot test.
module tb_slot_access_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      slot = 3'd0;
  logic [7:0]      req = '0;
  logic [7:0]      we = '0;
  logic [8*AW-1:0] addr = '0;
  logic [8*DW-1:0] wdata = '0;

  logic [7:0]    busy0, ack0, busy1, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en0, mem_we0, mem_en1, mem_we1;
  logic [AW-1:0] mem_addr0, mem_addr1;
  logic [DW-1:0] mem_wdata0, mem_wdata1;
  logic [DW-1:0] mrd0 = '0;
  logic [DW-1:0] mrd1 = '0;

  typedef struct {
    logic [2:0]  cl;
    logic [15:0] rd;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slot_access_ctrl #(.AW(AW), .DW(DW), .WORK_CONSERVE(0)) u_strict (
    .clk(clk), .rst(rst), .slot(slot), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy0), .ack(ack0), .rdata(rdata0), .mem_en(mem_en0), .mem_we(mem_we0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mrd0)
  );

  slot_access_ctrl #(.AW(AW), .DW(DW), .WORK_CONSERVE(1)) u_wc (
    .clk(clk), .rst(rst), .slot(slot), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy1), .ack(ack1), .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mrd1)
  );

  // Default memory content; 0x12 holds 0xBEEF.
  function automatic logic [15:0] mdef(input logic [7:0] a);
    return (a == 8'h12) ? 16'hBEEF : {~a, a};
  endfunction

  logic [15:0] st0 [256];
  bit          wr0 [256];
  logic [15:0] st1 [256];
  bit          wr1 [256];

  // Synchronous memory model for the strict instance.
  always @(posedge clk) begin
    if (mem_en0) begin
      if (mem_we0) begin
        st0[mem_addr0] <= mem_wdata0;
        wr0[mem_addr0] <= 1'b1;
      end else begin
        mrd0 <= wr0[mem_addr0] ? st0[mem_addr0] : mdef(mem_addr0);
      end
    end
  end

  // Synchronous memory model for the work-conserving instance.
  always @(posedge clk) begin
    if (mem_en1) begin
      if (mem_we1) begin
        st1[mem_addr1] <= mem_wdata1;
        wr1[mem_addr1] <= 1'b1;
      end else begin
        mrd1 <= wr1[mem_addr1] ? st1[mem_addr1] : mdef(mem_addr1);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ack scoreboard for the strict instance, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && ack0 !== 8'h00) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack0), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("sb_ack_owner", 32'(ack0), 32'(8'b1 << e.cl));
        chk("sb_ack_rdata", 32'(rdata0), 32'(e.rd));
      end
    end
  end

  // One cycle: outputs of the new cycle are stable at #1; slot advances, req pulses end.
  task automatic step();
    @(posedge clk);
    #1;
    req  = '0;
    slot = slot + 3'd1;
  endtask

  task automatic goto_slot(input logic [2:0] s);
    for (int n = 0; n < 8 && slot != s; n++) step();
  endtask

  task automatic post(input int c, input logic w, input logic [7:0] a, input logic [15:0] d);
    req[c]           = 1'b1;
    we[c]            = w;
    addr[c*AW +: AW] = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic push(input int c, input logic [15:0] d);
    exp_t e;
    e.cl = 3'(c);
    e.rd = d;
    sb.push_back(e);
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b0;
    #2;
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_ack", 32'(ack0), 32'h0);
    chk("rst_rdata", 32'(rdata0), 32'h0);
    chk("rst_mem_en", 32'(mem_en0), 32'h0);
    chk("rst_mem_we", 32'(mem_we0), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr0), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata0), 32'h0);
    chk("rst_busy_wc", 32'(busy1), 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Strict read: client 3 posted at slot 5, issued after slot 3
    goto_slot(3'd5);
    post(3, 1'b0, 8'h12, 16'h0);
    push(3, 16'hBEEF);
    step();
    chk("rd_busy_cap", 32'(busy0[3]), 32'h1);
    chk("rd_no_issue_s6", 32'(mem_en0), 32'h0);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("rd_wait_mem_en", 32'(mem_en0), 32'h0);
      chk("rd_wait_busy", 32'(busy0[3]), 32'h1);
    end
    step();
    chk("rd_mem_en", 32'(mem_en0), 32'h1);
    chk("rd_mem_addr", 32'(mem_addr0), 32'h12);
    chk("rd_mem_we", 32'(mem_we0), 32'h0);
    chk("rd_busy_flight", 32'(busy0[3]), 32'h1);
    step();
    chk("rd_ack", 32'(ack0), 32'h08);
    chk("rd_rdata", 32'(rdata0), 32'hBEEF);
    chk("rd_busy_done", 32'(busy0[3]), 32'h0);

    // Write then read by client 6, each issued only after slot 6
    post(6, 1'b1, 8'h40, 16'hA5A5);
    push(6, 16'h0000);
    step();
    chk("wr_no_issue_s6", 32'(mem_en0), 32'h0);
    chk("wr_busy", 32'(busy0[6]), 32'h1);
    step();
    chk("wr_mem_en", 32'(mem_en0), 32'h1);
    chk("wr_mem_we", 32'(mem_we0), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr0), 32'h40);
    chk("wr_mem_wdata", 32'(mem_wdata0), 32'hA5A5);
    step();
    chk("wr_ack", 32'(ack0), 32'h40);
    chk("wr_rdata_zero", 32'(rdata0), 32'h0);
    chk("wr_busy_done", 32'(busy0[6]), 32'h0);
    post(6, 1'b0, 8'h40, 16'h0);
    push(6, 16'hA5A5);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("rd2_wait_mem_en", 32'(mem_en0), 32'h0);
      chk("rd2_busy", 32'(busy0[6]), 32'h1);
    end
    step();
    chk("rd2_mem_en", 32'(mem_en0), 32'h1);
    chk("rd2_mem_addr", 32'(mem_addr0), 32'h40);
    chk("rd2_mem_we", 32'(mem_we0), 32'h0);
    step();
    chk("rd2_ack", 32'(ack0), 32'h40);
    chk("rd2_rdata", 32'(rdata0), 32'hA5A5);

    // Back-to-back: all clients posted at slot 0
    for (int c = 0; c < 8; c++) post(c, 1'b0, 8'(32'h20 + c), 16'h0);
    for (int c = 1; c <= 8; c++) push(c % 8, mdef(8'(32'h20 + (c % 8))));
    step();
    chk("b2b_first_idle", 32'(mem_en0), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("b2b_mem_en", 32'(mem_en0), 32'h1);
      chk("b2b_mem_addr", 32'(mem_addr0), 32'h20 + 32'((k + 1) % 8));
      if (k >= 1) chk("b2b_ack_seq", 32'(ack0), 32'(1) << k);
    end
    step();
    chk("b2b_end_idle", 32'(mem_en0), 32'h0);
    chk("b2b_last_ack", 32'(ack0), 32'h01);
    step();
    chk("b2b_no_ack", 32'(ack0), 32'h0);

    // Ignored re-request while busy
    post(2, 1'b0, 8'h30, 16'h0);
    push(2, mdef(8'h30));
    step();
    chk("ign_busy", 32'(busy0[2]), 32'h1);
    post(2, 1'b0, 8'h99, 16'h0);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("ign_wait_mem_en", 32'(mem_en0), 32'h0);
    end
    step();
    chk("ign_mem_en", 32'(mem_en0), 32'h1);
    chk("ign_mem_addr", 32'(mem_addr0), 32'h30);
    step();
    chk("ign_ack", 32'(ack0), 32'h04);
    chk("ign_busy_done", 32'(busy0[2]), 32'h0);
    for (int n = 0; n < 8; n++) begin
      step();
      chk("ign_no_reissue", 32'(mem_en0), 32'h0);
    end

    // Work-conserving vs strict: client 5 pending at slot 1
    goto_slot(3'd0);
    post(5, 1'b0, 8'h50, 16'h0);
    push(5, mdef(8'h50));
    step();
    chk("wc_busy", 32'(busy1[5]), 32'h1);
    chk("wc_strict_busy", 32'(busy0[5]), 32'h1);
    step();
    chk("wc_mem_en", 32'(mem_en1), 32'h1);
    chk("wc_mem_addr", 32'(mem_addr1), 32'h50);
    chk("wc_strict_idle", 32'(mem_en0), 32'h0);
    step();
    chk("wc_ack", 32'(ack1), 32'h20);
    chk("wc_rdata", 32'(rdata1), 32'(mdef(8'h50)));
    chk("wc_busy_done", 32'(busy1[5]), 32'h0);
    chk("wc_strict_no_ack", 32'(ack0), 32'h0);
    step();
    chk("st5_wait_a", 32'(mem_en0), 32'h0);
    step();
    chk("st5_wait_b", 32'(mem_en0), 32'h0);
    step();
    chk("st5_mem_en", 32'(mem_en0), 32'h1);
    chk("st5_mem_addr", 32'(mem_addr0), 32'h50);
    step();
    chk("st5_ack", 32'(ack0), 32'h20);

    // Reset mid-flight: in-flight read from client 4 is dropped
    goto_slot(3'd1);
    post(4, 1'b0, 8'h12, 16'h0);
    step();
    chk("mf_busy", 32'(busy0[4]), 32'h1);
    step();
    step();
    step();
    chk("mf_mem_en", 32'(mem_en0), 32'h1);
    chk("mf_mem_addr", 32'(mem_addr0), 32'h12);
    rst = 1'b0;
    #1;
    chk("mf_rst_mem_en", 32'(mem_en0), 32'h0);
    chk("mf_rst_busy", 32'(busy0), 32'h0);
    chk("mf_rst_ack", 32'(ack0), 32'h0);
    chk("mf_rst_mem_addr", 32'(mem_addr0), 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      chk("mf_post_ack", 32'(ack0), 32'h0);
      chk("mf_post_mem_en", 32'(mem_en0), 32'h0);
    end
    chk("mf_post_busy", 32'(busy0), 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
